// File: rtl/zipdma_mm2s_pkg.sv
// Shared helpers for the ZipDMA memory-to-stream read engine.
// Bus geometry is derived here so the top and any future siblings agree on it.
package zipdma_mm2s_pkg;

    function automatic int bytesLog2(input int busWidth);
        return $clog2(busWidth / 8);
    endfunction

endpackage

// File: rtl/zipdma_rxfifo.sv
// Synchronous receive FIFO holding read words plus a last-of-transfer flag.
// The extra pointer bit distinguishes full from empty; flush empties it in one cycle.
module zipdma_rxfifo #(
    parameter int WIDTH  = 33,
    parameter int LGFLEN = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             wr_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             rd_i,
    output logic [WIDTH-1:0] data_o,
    output logic             empty_o,
    output logic [LGFLEN:0]  fill_o
);

    logic [WIDTH-1:0] mem_q [0:(1<<LGFLEN)-1];
    logic [LGFLEN:0]  wrPtr_q, wrPtr_d;
    logic [LGFLEN:0]  rdPtr_q, rdPtr_d;

    assign fill_o  = wrPtr_q - rdPtr_q;
    assign empty_o = (fill_o == '0);
    assign data_o  = mem_q[rdPtr_q[LGFLEN-1:0]];

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        if (flush_i) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
        end else begin
            if (wr_i)
                wrPtr_d = wrPtr_q + (LGFLEN+1)'(1);
            if (rd_i && !empty_o)
                rdPtr_d = rdPtr_q + (LGFLEN+1)'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
        end
    end

    // Storage is not reset; only the pointers define what is valid.
    always_ff @(posedge clk_i) begin
        if (wr_i && !flush_i)
            mem_q[wrPtr_q[LGFLEN-1:0]] <= data_i;
    end

endmodule

// File: rtl/zipdma_mm2s.sv
// ZipDMA MM2S: reads a block over pipelined Wishbone and streams it to the S2MM stage.
// Strobes are throttled so in-flight reads plus buffered words never exceed the FIFO depth.
module zipdma_mm2s
    import zipdma_mm2s_pkg::*;
#(
    parameter  int ADDRESS_WIDTH = 32,
    parameter  int BUS_WIDTH     = 32,
    parameter  int LGSUBLENGTH   = 10,
    localparam int WSHIFT        = bytesLog2(BUS_WIDTH),
    localparam int LGFIFO        = LGSUBLENGTH - WSHIFT
) (
    input  logic                            i_clk,
    input  logic                            i_reset_n,
    input  logic                            i_soft_reset,
    input  logic                            i_request,
    output logic                            o_busy,
    output logic                            o_err,
    input  logic                            i_inc,
    input  logic [ADDRESS_WIDTH-1:0]        i_addr,
    input  logic [LGSUBLENGTH:0]            i_transferlen,
    output logic                            o_wb_cyc,
    output logic                            o_wb_stb,
    output logic                            o_wb_we,
    output logic [ADDRESS_WIDTH-WSHIFT-1:0] o_wb_addr,
    output logic [BUS_WIDTH/8-1:0]          o_wb_sel,
    input  logic                            i_wb_stall,
    input  logic                            i_wb_ack,
    input  logic                            i_wb_err,
    input  logic [BUS_WIDTH-1:0]            i_wb_data,
    output logic                            M_VALID,
    input  logic                            M_READY,
    output logic [BUS_WIDTH-1:0]            M_DATA,
    output logic                            M_LAST
);

    localparam int          WAW   = ADDRESS_WIDTH - WSHIFT;
    localparam int          CW    = LGFIFO + 1;
    localparam logic [CW:0] DEPTH = (CW+1)'(1) << LGFIFO;

    typedef enum logic [1:0] {IDLE = 2'd0, BUS = 2'd1, ERR = 2'd2} state_t;

    state_t           state_q, state_d;
    logic [WAW-1:0]   addr_q, addr_d;
    logic             inc_q, inc_d;
    logic [CW-1:0]    len_q, len_d;
    logic [CW-1:0]    stbCnt_q, stbCnt_d;
    logic [CW-1:0]    ackCnt_q, ackCnt_d;
    logic             cyc_q, cyc_d;

    logic [CW-1:0]    outstanding;
    logic [CW:0]      committed;
    logic [CW-1:0]    fifoFill;
    logic             fifoEmpty;
    logic [BUS_WIDTH:0] fifoHead;
    logic             stbAccept, ackPush, busErr, lastAck, misaligned, fifoFlush;

    assign outstanding = stbCnt_q - ackCnt_q;
    assign committed   = {1'b0, outstanding} + {1'b0, fifoFill};

    assign o_wb_stb  = cyc_q && (stbCnt_q < len_q) && (committed < DEPTH);
    assign o_wb_cyc  = cyc_q;
    assign o_wb_we   = 1'b0;
    assign o_wb_addr = addr_q;
    assign o_wb_sel  = '1;
    assign o_busy    = (state_q != IDLE);
    assign o_err     = (state_q == ERR);

    assign stbAccept  = o_wb_stb && !i_wb_stall;
    assign ackPush    = cyc_q && i_wb_ack && !i_wb_err;
    assign busErr     = cyc_q && i_wb_err;
    assign lastAck    = (ackCnt_q == len_q - CW'(1));
    assign misaligned = (|i_addr[WSHIFT-1:0]) || (|i_transferlen[WSHIFT-1:0]);
    assign fifoFlush  = i_soft_reset || busErr;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        inc_d    = inc_q;
        len_d    = len_q;
        stbCnt_d = stbCnt_q;
        ackCnt_d = ackCnt_q;
        cyc_d    = cyc_q;

        if (stbAccept) begin
            stbCnt_d = stbCnt_q + CW'(1);
            if (inc_q)
                addr_d = addr_q + WAW'(1);
        end

        case (state_q)
            IDLE: begin
                if (i_request) begin
                    if (misaligned) begin
                        state_d = ERR;
                    end else begin
                        state_d  = BUS;
                        addr_d   = i_addr[ADDRESS_WIDTH-1:WSHIFT];
                        inc_d    = i_inc;
                        len_d    = i_transferlen[LGSUBLENGTH:WSHIFT];
                        stbCnt_d = '0;
                        ackCnt_d = '0;
                        cyc_d    = |i_transferlen[LGSUBLENGTH:WSHIFT];
                    end
                end
            end
            BUS: begin
                // A zero-length transfer never raises cyc and leaves after one cycle.
                if (busErr) begin
                    state_d = ERR;
                    cyc_d   = 1'b0;
                end else if (ackPush) begin
                    ackCnt_d = ackCnt_q + CW'(1);
                    if (lastAck) begin
                        state_d = IDLE;
                        cyc_d   = 1'b0;
                    end
                end else if (!cyc_q) begin
                    state_d = IDLE;
                end
            end
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (i_soft_reset) begin
            state_d = IDLE;
            cyc_d   = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            inc_q    <= 1'b0;
            len_q    <= '0;
            stbCnt_q <= '0;
            ackCnt_q <= '0;
            cyc_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            inc_q    <= inc_d;
            len_q    <= len_d;
            stbCnt_q <= stbCnt_d;
            ackCnt_q <= ackCnt_d;
            cyc_q    <= cyc_d;
        end
    end

    zipdma_rxfifo #(
        .WIDTH  (BUS_WIDTH + 1),
        .LGFLEN (LGFIFO)
    ) u_rxfifo (
        .clk_i   (i_clk),
        .rst_ni  (i_reset_n),
        .flush_i (fifoFlush),
        .wr_i    (ackPush),
        .data_i  ({lastAck, i_wb_data}),
        .rd_i    (M_VALID && M_READY),
        .data_o  (fifoHead),
        .empty_o (fifoEmpty),
        .fill_o  (fifoFill)
    );

    assign M_VALID = !fifoEmpty;
    assign M_DATA  = fifoHead[BUS_WIDTH-1:0];
    assign M_LAST  = fifoHead[BUS_WIDTH] && !fifoEmpty;

endmodule

// File: tb/tb_zipdma_mm2s.sv
// Directed bench for zipdma_mm2s: a Wishbone slave model with one-cycle ack latency
// feeds the DUT, a stream monitor captures M_* output, and checks compare against hand values.
module tb_zipdma_mm2s;

    logic        i_clk = 1'b0;
    logic        i_reset_n = 1'b0;
    logic        i_soft_reset = 1'b0;
    logic        i_request = 1'b0;
    logic        o_busy, o_err;
    logic        i_inc = 1'b1;
    logic [31:0] i_addr = '0;
    logic [10:0] i_transferlen = '0;
    logic        o_wb_cyc, o_wb_stb, o_wb_we;
    logic [29:0] o_wb_addr;
    logic [3:0]  o_wb_sel;
    logic        i_wb_stall = 1'b0;
    logic        i_wb_ack = 1'b0;
    logic        i_wb_err = 1'b0;
    logic [31:0] i_wb_data = '0;
    logic        M_VALID, M_LAST;
    logic        M_READY = 1'b0;
    logic [31:0] M_DATA;

    always #5 i_clk = ~i_clk;

    zipdma_mm2s dut (
        .i_clk         (i_clk),
        .i_reset_n     (i_reset_n),
        .i_soft_reset  (i_soft_reset),
        .i_request     (i_request),
        .o_busy        (o_busy),
        .o_err         (o_err),
        .i_inc         (i_inc),
        .i_addr        (i_addr),
        .i_transferlen (i_transferlen),
        .o_wb_cyc      (o_wb_cyc),
        .o_wb_stb      (o_wb_stb),
        .o_wb_we       (o_wb_we),
        .o_wb_addr     (o_wb_addr),
        .o_wb_sel      (o_wb_sel),
        .i_wb_stall    (i_wb_stall),
        .i_wb_ack      (i_wb_ack),
        .i_wb_err      (i_wb_err),
        .i_wb_data     (i_wb_data),
        .M_VALID       (M_VALID),
        .M_DATA        (M_DATA),
        .M_LAST        (M_LAST),
        .M_READY       (M_READY)
    );

    typedef struct {
        logic [31:0] addr;
        logic [10:0] len;
        logic        inc;
        logic [7:0]  stallMask;
        int          words;
        int          expErr;
        logic [29:0] firstWord;
    } vec_t;

    vec_t vecs [8];

    int assertCount = 0;
    int failCount   = 0;

    logic       readyEnable = 1'b0;
    logic       holdAcks    = 1'b0;
    int         maxAccept   = 0;
    int         errAt       = 0;
    logic [7:0] stallMask   = '0;

    logic [31:0] pendQ[$];
    logic [29:0] addrLog[$];
    int          acceptCount = 0;
    int          ackNum      = 0;
    int          cycleCnt    = 0;
    logic [31:0] slaveWord;

    logic [31:0] streamData[$];
    logic        streamLast[$];

    // Slave model: ack each accepted strobe one cycle later with data tagged by address and order.
    always @(negedge i_clk) begin
        cycleCnt++;
        i_wb_ack  = 1'b0;
        i_wb_err  = 1'b0;
        i_wb_data = '0;
        if (!holdAcks && pendQ.size() > 0) begin
            slaveWord = pendQ.pop_front();
            ackNum++;
            if (ackNum == errAt) begin
                i_wb_err = 1'b1;
            end else begin
                i_wb_ack  = 1'b1;
                i_wb_data = slaveWord;
            end
        end
        i_wb_stall = stallMask[cycleCnt % 8] || (maxAccept > 0 && acceptCount >= maxAccept);
        if (o_wb_stb && !i_wb_stall) begin
            addrLog.push_back(o_wb_addr);
            pendQ.push_back({8'hD0, o_wb_addr[15:0], acceptCount[7:0]});
            acceptCount++;
        end
    end

    always @(negedge i_clk) begin
        M_READY = readyEnable;
        if (M_VALID && M_READY) begin
            streamData.push_back(M_DATA);
            streamLast.push_back(M_LAST);
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic resetSlave();
        pendQ.delete();
        addrLog.delete();
        acceptCount = 0;
        ackNum      = 0;
        streamData.delete();
        streamLast.delete();
    endtask

    task automatic issueRequest(input logic [31:0] addr, input logic [10:0] len, input logic inc);
        @(negedge i_clk);
        i_addr        = addr;
        i_transferlen = len;
        i_inc         = inc;
        i_request     = 1'b1;
        @(negedge i_clk);
        i_request     = 1'b0;
    endtask

    task automatic waitIdle(input int bound);
        int n = 0;
        while (o_busy && n < bound) begin
            @(negedge i_clk);
            n++;
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        int          n;
        int          busyCycles;
        int          errCycles;
        logic        cycSeen;
        logic [29:0] expAddr;
        logic [63:0] actual;
        resetSlave();
        stallMask = v.stallMask;
        issueRequest(v.addr, v.len, v.inc);
        checkOutput("busyAfterAccept", o_busy, 1);
        busyCycles = 0;
        errCycles  = 0;
        cycSeen    = 1'b0;
        n          = 0;
        while (o_busy && n < 3000) begin
            busyCycles++;
            if (o_err) errCycles++;
            if (o_wb_cyc) cycSeen = 1'b1;
            @(negedge i_clk);
            n++;
        end
        checkOutput("busyFalls", o_busy, 0);
        n = 0;
        while (streamData.size() < v.words && n < 600) begin
            @(negedge i_clk);
            n++;
        end
        repeat (4) @(negedge i_clk);
        stallMask = '0;
        checkOutput("errCycles", errCycles, v.expErr);
        if (v.words == 0)
            checkOutput("shortBusy", busyCycles, 1);
        checkOutput("cycSeen", cycSeen, v.words > 0);
        checkOutput("strobes", addrLog.size(), v.words);
        checkOutput("streamWords", streamData.size(), v.words);
        for (int i = 0; i < v.words; i++) begin
            expAddr = v.inc ? v.firstWord + 30'(i) : v.firstWord;
            actual  = (i < addrLog.size()) ? 64'(addrLog[i]) : '1;
            checkOutput("wordAddr", actual, expAddr);
            actual  = (i < streamData.size()) ? 64'(streamData[i]) : '1;
            checkOutput("streamData", actual, {8'hD0, expAddr[15:0], 8'(i)});
            actual  = (i < streamLast.size()) ? 64'(streamLast[i]) : '1;
            checkOutput("streamLast", actual, i == v.words - 1);
        end
    endtask

    initial begin
        int          n;
        int          badWords;
        int          lastCount;
        logic        prevCyc;
        logic [31:0] expWord;

        vecs[0] = '{32'h0000_0100, 11'd16, 1'b1, 8'h00, 4,  0, 30'h40};
        vecs[1] = '{32'h0000_0100, 11'd8,  1'b0, 8'h00, 2,  0, 30'h40};
        vecs[2] = '{32'h0000_0102, 11'd16, 1'b1, 8'h00, 0,  1, 30'h0};
        vecs[3] = '{32'h0000_0100, 11'd6,  1'b1, 8'h00, 0,  1, 30'h0};
        vecs[4] = '{32'h0000_0300, 11'd0,  1'b1, 8'h00, 0,  0, 30'h0};
        vecs[5] = '{32'hFFFF_FFF8, 11'd16, 1'b1, 8'h69, 4,  0, 30'h3FFF_FFFE};
        vecs[6] = '{32'h0000_0200, 11'd4,  1'b1, 8'hF0, 1,  0, 30'h80};
        vecs[7] = '{32'h0000_1000, 11'd40, 1'b1, 8'hAA, 10, 0, 30'h400};

        $display("[TB] zipdma_mm2s bench starting");
        repeat (3) @(negedge i_clk);
        checkOutput("rstBusy",  o_busy,    0);
        checkOutput("rstErr",   o_err,     0);
        checkOutput("rstCyc",   o_wb_cyc,  0);
        checkOutput("rstStb",   o_wb_stb,  0);
        checkOutput("rstAddr",  o_wb_addr, 0);
        checkOutput("rstValid", M_VALID,   0);
        checkOutput("rstLast",  M_LAST,    0);
        i_reset_n = 1'b1;
        @(negedge i_clk);

        readyEnable = 1'b1;
        for (int k = 0; k < 8; k++)
            applyStimulus(vecs[k]);

        // Backpressure: a full 256-word transfer must complete into the FIFO with no pops,
        // and a follow-on request must not strobe until space frees up.
        resetSlave();
        readyEnable = 1'b0;
        issueRequest(32'h0, 11'd1024, 1'b1);
        waitIdle(3000);
        checkOutput("bpBusyFalls", o_busy, 0);
        checkOutput("bpNoPop", streamData.size(), 0);
        checkOutput("bpValid", M_VALID, 1);
        checkOutput("bpStrobes", acceptCount, 256);
        issueRequest(32'h100, 11'd16, 1'b1);
        repeat (10) @(negedge i_clk);
        checkOutput("bpFullNoStrobe", acceptCount, 256);
        checkOutput("bpFullBusy", o_busy, 1);
        readyEnable = 1'b1;
        n = 0;
        while ((streamData.size() < 260 || o_busy) && n < 1000) begin
            @(negedge i_clk);
            n++;
        end
        repeat (4) @(negedge i_clk);
        checkOutput("bpDrainCount", streamData.size(), 260);
        badWords  = 0;
        lastCount = 0;
        for (int i = 0; i < streamData.size(); i++) begin
            expWord = (i < 256) ? {8'hD0, 16'(i), 8'(i)} : {8'hD0, 16'(32'h40 + i - 256), 8'(i)};
            if (streamData[i] !== expWord) badWords++;
            if (streamLast[i]) lastCount++;
        end
        checkOutput("bpOrder", badWords, 0);
        checkOutput("bpLastCount", lastCount, 2);
        checkOutput("bpLast255", (streamLast.size() > 255) ? streamLast[255] : 1'b0, 1);
        checkOutput("bpLast259", (streamLast.size() > 259) ? streamLast[259] : 1'b0, 1);

        // Bus error on the second ack, with the first word still parked in the FIFO.
        resetSlave();
        readyEnable = 1'b0;
        errAt = 2;
        issueRequest(32'h600, 11'd16, 1'b1);
        prevCyc = 1'b0;
        n = 0;
        while (!o_err && n < 50) begin
            prevCyc = o_wb_cyc;
            @(negedge i_clk);
            n++;
        end
        checkOutput("errSeen", o_err, 1);
        checkOutput("errCycBefore", prevCyc, 1);
        checkOutput("errCycDropped", o_wb_cyc, 0);
        checkOutput("errStbDropped", o_wb_stb, 0);
        checkOutput("errBusy", o_busy, 1);
        checkOutput("errFlushed", M_VALID, 0);
        @(negedge i_clk);
        checkOutput("errOneCycle", o_err, 0);
        checkOutput("errIdle", o_busy, 0);
        errAt = 0;
        repeat (6) @(negedge i_clk);
        readyEnable = 1'b1;
        repeat (4) @(negedge i_clk);
        checkOutput("errNoStream", streamData.size(), 0);

        // Soft reset with two reads outstanding; their late acks must be ignored.
        resetSlave();
        readyEnable = 1'b0;
        holdAcks    = 1'b1;
        maxAccept   = 2;
        issueRequest(32'h500, 11'd16, 1'b1);
        n = 0;
        while (acceptCount < 2 && n < 50) begin
            @(negedge i_clk);
            n++;
        end
        checkOutput("srOutstanding", acceptCount, 2);
        i_soft_reset = 1'b1;
        @(negedge i_clk);
        i_soft_reset = 1'b0;
        checkOutput("srBusy", o_busy, 0);
        checkOutput("srErr", o_err, 0);
        checkOutput("srCyc", o_wb_cyc, 0);
        checkOutput("srStb", o_wb_stb, 0);
        holdAcks  = 1'b0;
        maxAccept = 0;
        repeat (6) @(negedge i_clk);
        checkOutput("srLateAckValid", M_VALID, 0);
        readyEnable = 1'b1;
        repeat (4) @(negedge i_clk);
        checkOutput("srNoStream", streamData.size(), 0);

        applyStimulus(vecs[0]);

        // Asynchronous reset between clock edges must clear outputs immediately.
        resetSlave();
        readyEnable = 1'b0;
        issueRequest(32'h100, 11'd8, 1'b1);
        waitIdle(100);
        repeat (2) @(negedge i_clk);
        checkOutput("preRstValid", M_VALID, 1);
        #2;
        i_reset_n = 1'b0;
        #1;
        checkOutput("asyncValid", M_VALID, 0);
        checkOutput("asyncAddr", o_wb_addr, 0);
        checkOutput("asyncBusy", o_busy, 0);
        @(negedge i_clk);
        i_reset_n = 1'b1;
        @(negedge i_clk);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
